// File: rtl/ram_sdp_arbiter_if.sv
// ram_sdp_arbiter_if
//   Bundles the requester-side handshakes, the read-response channel and the
//   RAM-side port of ram_sdp_arbiter.
//   slave  : arbiter view (requests/dout in, grants/responses/RAM controls out)
//   master : requester + RAM view (the mirror of slave)
//   Signals:
//     wr_valid/wr_ready[1:0], wr_addr0/1, wr_data0/1   write requesters
//     rd_valid/rd_ready[1:0], rd_addr0/1               read requesters
//     rsp_valid, rsp_id, rsp_data                      tagged read response
//     init_done                                        zero-fill finished
//     we, write_addr, din, read_addr, dout             RAM ports
`timescale 1ns/1ps
interface ram_sdp_arbiter_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 64
);
    logic [1:0]    wr_valid;
    logic [1:0]    wr_ready;
    logic [AW-1:0] wr_addr0;
    logic [AW-1:0] wr_addr1;
    logic [DW-1:0] wr_data0;
    logic [DW-1:0] wr_data1;
    logic [1:0]    rd_valid;
    logic [1:0]    rd_ready;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic          rsp_valid;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic          we;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] din;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] dout;

    modport slave (
        input  wr_valid, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  rd_valid, rd_addr0, rd_addr1, dout,
        output wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data, init_done,
        output we, write_addr, din, read_addr
    );

    modport master (
        output wr_valid, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output rd_valid, rd_addr0, rd_addr1, dout,
        input  wr_ready, rd_ready, rsp_valid, rsp_id, rsp_data, init_done,
        input  we, write_addr, din, read_addr
    );
endinterface

// File: rtl/ram_sdp_arbiter.sv
// ram_sdp_arbiter
//   Front-end for one simple dual-port RAM with registered read. After reset
//   it zero-fills DEPTH words, then shares the write port between two write
//   requesters and the read port between two read requesters using an
//   independent round-robin per port. Read responses are tagged with the
//   requester index. A read granted to the address being written in the same
//   cycle is held off one cycle so it returns the new data.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    ram_sdp_arbiter_if.slave (requests, grants, responses, RAM port)
`timescale 1ns/1ps
module ram_sdp_arbiter #(
    parameter int unsigned AW     = 11,
    parameter int unsigned DW     = 64,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned RD_LAT = 1
) (
    input logic                clk,
    input logic                rst_n,
    ram_sdp_arbiter_if.slave   bus
);

    localparam logic [AW-1:0] INIT_LAST = AW'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_e;

    state_e          state_q;
    logic [AW-1:0]   init_cnt_q;
    logic            init_done_q;
    logic            wr_ptr_q;       // requester favoured when both write
    logic            rd_ptr_q;       // requester favoured when both read
    logic [AW-1:0]   waddr_q;        // last RAM write address (held when idle)
    logic [DW-1:0]   wdata_q;        // last RAM write data (held when idle)
    logic [RD_LAT-1:0] pipe_v_q;
    logic [RD_LAT-1:0] pipe_id_q;

    logic            run;
    logic            init_we;
    logic            wr_any;
    logic            rd_any;
    logic            wr_idx;
    logic            rd_idx;
    logic [AW-1:0]   wr_addr_g;
    logic [DW-1:0]   wr_data_g;
    logic [AW-1:0]   rd_addr_g;
    logic            collide;
    logic            wr_xfer;
    logic            rd_xfer;

    always_comb begin
        run       = (state_q == RUN);
        // Gated by rst_n so the RAM write enable drops asynchronously.
        init_we   = (state_q == INIT) && rst_n;

        wr_any    = |bus.wr_valid;
        wr_idx    = (&bus.wr_valid) ? wr_ptr_q : bus.wr_valid[1];
        wr_addr_g = wr_idx ? bus.wr_addr1 : bus.wr_addr0;
        wr_data_g = wr_idx ? bus.wr_data1 : bus.wr_data0;

        rd_any    = |bus.rd_valid;
        rd_idx    = (&bus.rd_valid) ? rd_ptr_q : bus.rd_valid[1];
        rd_addr_g = rd_idx ? bus.rd_addr1 : bus.rd_addr0;

        // Same-address read/write: the write wins, the read retries next cycle.
        collide   = run && wr_any && rd_any && (wr_addr_g == rd_addr_g);
        wr_xfer   = run && wr_any;
        rd_xfer   = run && rd_any && !collide;
    end

    assign bus.wr_ready   = {wr_xfer & wr_idx, wr_xfer & ~wr_idx};
    assign bus.rd_ready   = {rd_xfer & rd_idx, rd_xfer & ~rd_idx};

    assign bus.we         = init_we | wr_xfer;
    assign bus.write_addr = init_we ? init_cnt_q : (wr_xfer ? wr_addr_g : waddr_q);
    assign bus.din        = init_we ? '0 : (wr_xfer ? wr_data_g : wdata_q);
    assign bus.read_addr  = run ? rd_addr_g : '0;

    assign bus.init_done  = init_done_q;
    assign bus.rsp_valid  = pipe_v_q[RD_LAT-1];
    assign bus.rsp_id     = pipe_id_q[RD_LAT-1];
    assign bus.rsp_data   = pipe_v_q[RD_LAT-1] ? bus.dout : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pipe_v_q    <= '0;
            pipe_id_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    waddr_q    <= init_cnt_q;
                    wdata_q    <= '0;
                    if (init_cnt_q == INIT_LAST) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr_xfer) begin
                        wr_ptr_q <= ~wr_idx;
                        waddr_q  <= wr_addr_g;
                        wdata_q  <= wr_data_g;
                    end
                    if (rd_xfer) begin
                        rd_ptr_q <= ~rd_idx;
                    end
                end
                default: state_q <= INIT;
            endcase

            // Response tag follows the RAM read latency.
            pipe_v_q[0]  <= rd_xfer;
            pipe_id_q[0] <= rd_idx;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v_q[i]  <= pipe_v_q[i-1];
                pipe_id_q[i] <= pipe_id_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp_arbiter.sv
`timescale 1ns/1ps
module tb_ram_sdp_arbiter;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_sdp_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_sdp_arbiter #(.AW(AW), .DW(DW), .DEPTH(2048), .RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM model: registered read, one cycle latency; prefill port used only
    // while the controller is held in reset.
    logic [DW-1:0] ram [2048];
    logic [DW-1:0] ram_rd_q;
    logic          pf_en = 1'b0;
    logic [AW-1:0] pf_addr = '0;
    always @(posedge clk) begin
        if (pf_en) ram[pf_addr] <= {32'hA5A5_A5A5, 21'd0, pf_addr};
        else if (bus.we) ram[bus.write_addr] <= bus.din;
        ram_rd_q <= ram[bus.read_addr];
    end
    assign bus.dout = ram_rd_q;

    // Reference state
    logic [DW-1:0] model_mem [2048];
    logic          wptr_m, rptr_m;
    int            n_pass = 0;
    int            n_total = 0;

    logic [1:0]    obs_wr_ready, obs_rd_ready;
    logic          obs_we, obs_rsp_valid, obs_rsp_id;
    logic [DW-1:0] obs_rsp_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        wptr_m = 1'b0;
        rptr_m = 1'b0;
        for (int i = 0; i < 2048; i++) model_mem[i] = '0;
    endtask

    function automatic logic [AW-1:0] pick_addr(input logic hi);
        logic [AW-1:0] r;
        if ($urandom_range(0, 3) == 0) r = AW'($urandom_range(0, 1023));
        else r = AW'($urandom_range(0, 15));
        return hi ? (r + 11'd1024) : r;
    endfunction

    // One RUN-mode cycle: inputs must already be driven. Grants, RAM port and
    // the response are compared with the round-robin/collision reference.
    task automatic cycle();
        logic wx, rany, rx, wg, rg, coll;
        logic [AW-1:0] wad, rad;
        logic [DW-1:0] wdat, exp_rd;
        logic [1:0] ew, er;
        @(negedge clk);
        wx   = |bus.wr_valid;
        wg   = (bus.wr_valid == 2'b11) ? wptr_m : bus.wr_valid[1];
        wad  = wg ? bus.wr_addr1 : bus.wr_addr0;
        wdat = wg ? bus.wr_data1 : bus.wr_data0;
        rany = |bus.rd_valid;
        rg   = (bus.rd_valid == 2'b11) ? rptr_m : bus.rd_valid[1];
        rad  = rg ? bus.rd_addr1 : bus.rd_addr0;
        coll = wx && rany && (wad == rad);
        rx   = rany && !coll;
        ew   = wx ? (wg ? 2'b10 : 2'b01) : 2'b00;
        er   = rx ? (rg ? 2'b10 : 2'b01) : 2'b00;
        check("wr_ready", 64'(bus.wr_ready), 64'(ew));
        check("rd_ready", 64'(bus.rd_ready), 64'(er));
        check("we", 64'(bus.we), 64'(wx));
        if (wx) begin
            check("write_addr", 64'(bus.write_addr), 64'(wad));
            check("din", bus.din, wdat);
        end
        if (rx) check("read_addr", 64'(bus.read_addr), 64'(rad));
        obs_wr_ready = bus.wr_ready;
        obs_rd_ready = bus.rd_ready;
        obs_we       = bus.we;
        exp_rd       = model_mem[rad];
        @(posedge clk);
        if (wx) begin
            model_mem[wad] = wdat;
            wptr_m = ~wg;
        end
        if (rx) rptr_m = ~rg;
        #1;
        check("rsp_valid", 64'(bus.rsp_valid), 64'(rx));
        if (rx) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(rg));
            check("rsp_data", bus.rsp_data, exp_rd);
        end
        obs_rsp_valid = bus.rsp_valid;
        obs_rsp_id    = bus.rsp_id;
        obs_rsp_data  = bus.rsp_data;
    endtask

    // Releases reset and follows INIT until init_done; returns at the falling
    // edge of the first cycle with init_done high (or after the bound).
    task automatic run_init(output int we_cnt, output int bad, output int done_cyc, output int rdy_seen);
        we_cnt = 0; bad = 0; done_cyc = 0; rdy_seen = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge clk);
            if (bus.init_done) begin
                done_cyc = i;
                break;
            end
            if (bus.we) begin
                if (bus.write_addr != AW'(we_cnt) || bus.din != '0) bad++;
                we_cnt++;
            end
            if (bus.wr_ready != 2'b00 || bus.rd_ready != 2'b00) rdy_seen++;
        end
    endtask

    function automatic logic [11:0] out_vec();
        return {bus.we, bus.wr_ready, bus.rd_ready, bus.rsp_valid, bus.rsp_id,
                bus.init_done, |bus.write_addr, |bus.din, |bus.read_addr, |bus.rsp_data};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we_cnt, bad, done_cyc, rdy_seen;
        logic [1:0] seq [4];

        bus.wr_valid = 2'b11; bus.rd_valid = 2'b11;
        bus.wr_addr0 = 11'd3; bus.wr_addr1 = 11'd4;
        bus.wr_data0 = 64'h1; bus.wr_data1 = 64'h2;
        bus.rd_addr0 = 11'd5; bus.rd_addr1 = 11'd6;
        model_reset();

        // Prefill RAM with non-zero data while the controller sits in reset.
        @(posedge clk); #1;
        pf_en = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            pf_addr = AW'(i);
            @(posedge clk); #1;
        end
        pf_en = 1'b0;
        check("reset_outputs", 64'(out_vec()), 64'd0);

        // Zero-fill, with a read of 1500 left pending throughout INIT.
        bus.wr_valid = 2'b00;
        bus.rd_valid = 2'b01; bus.rd_addr0 = 11'd1500;
        run_init(we_cnt, bad, done_cyc, rdy_seen);
        check("init_we_cycles", 64'(we_cnt), 64'd2048);
        check("init_addr_seq", 64'(bad), 64'd0);
        check("init_no_grant", 64'(rdy_seen), 64'd0);
        check("init_done_cycle", 64'(done_cyc), 64'd2049);
        check("pending_rd_ready", 64'(bus.rd_ready), 64'b01);
        check("pending_read_addr", 64'(bus.read_addr), 64'd1500);
        check("post_init_we", 64'(bus.we), 64'd0);
        @(posedge clk); #1;
        check("rd1500_valid", 64'(bus.rsp_valid), 64'd1);
        check("rd1500_id", 64'(bus.rsp_id), 64'd0);
        check("rd1500_data", bus.rsp_data, 64'd0);
        rptr_m = 1'b1;
        bus.rd_valid = 2'b00;

        // Write contention: grants 0,1,0,1.
        bus.wr_valid = 2'b11;
        bus.wr_addr0 = 11'd10; bus.wr_data0 = 64'h1010;
        bus.wr_addr1 = 11'd20; bus.wr_data1 = 64'h2020;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = obs_wr_ready;
            check("wr_cont_we", 64'(obs_we), 64'd1);
        end
        check("wr_cont_seq", {56'd0, seq[0], seq[1], seq[2], seq[3]}, 64'b01_10_01_10);
        bus.wr_valid = 2'b00;

        // Single write by req0, then read by req1.
        bus.wr_valid = 2'b01; bus.wr_addr0 = 11'd1030; bus.wr_data0 = 64'hDEADBEEF_01234567;
        cycle();
        check("single_wr_ready", 64'(obs_wr_ready), 64'b01);
        bus.wr_valid = 2'b00;
        bus.rd_valid = 2'b10; bus.rd_addr1 = 11'd1030;
        cycle();
        check("single_rd_ready", 64'(obs_rd_ready), 64'b10);
        check("single_rsp_valid", 64'(obs_rsp_valid), 64'd1);
        check("single_rsp_id", 64'(obs_rsp_id), 64'd1);
        check("single_rsp_data", obs_rsp_data, 64'hDEADBEEF_01234567);
        bus.rd_valid = 2'b00;

        // Read contention: response ids 0,1,0,1; readback of contention writes.
        bus.rd_valid = 2'b11; bus.rd_addr0 = 11'd5; bus.rd_addr1 = 11'd6;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = {obs_rsp_valid, obs_rsp_id};
        end
        check("rd_cont_ids", {56'd0, seq[0], seq[1], seq[2], seq[3]}, 64'b10_11_10_11);
        bus.rd_valid = 2'b01; bus.rd_addr0 = 11'd10;
        cycle();
        check("rd_addr10", obs_rsp_data, 64'h1010);
        bus.rd_addr0 = 11'd20;
        cycle();
        check("rd_addr20", obs_rsp_data, 64'h2020);
        bus.rd_valid = 2'b00;

        // Collision on address 700.
        bus.wr_valid = 2'b01; bus.wr_addr0 = 11'd700; bus.wr_data0 = 64'h55;
        bus.rd_valid = 2'b01; bus.rd_addr0 = 11'd700;
        cycle();
        check("coll_rd_blocked", 64'(obs_rd_ready), 64'b00);
        check("coll_wr_done", 64'(obs_wr_ready), 64'b01);
        bus.wr_valid = 2'b00;
        cycle();
        check("coll_rd_accept", 64'(obs_rd_ready), 64'b01);
        check("coll_rd_data", obs_rsp_data, 64'h55);
        bus.rd_valid = 2'b00;

        // Random traffic.
        for (int i = 0; i < 6 * 2048; i++) begin
            bus.wr_valid = 2'($urandom_range(0, 3));
            bus.rd_valid = 2'($urandom_range(0, 3));
            bus.wr_addr0 = pick_addr(1'b0);
            bus.wr_addr1 = pick_addr(1'b1);
            bus.rd_addr0 = pick_addr(1'b0);
            bus.rd_addr1 = pick_addr(1'b1);
            bus.wr_data0 = {$urandom, $urandom};
            bus.wr_data1 = {$urandom, $urandom};
            cycle();
        end
        bus.wr_valid = 2'b00; bus.rd_valid = 2'b00;

        // Reset in the middle of INIT.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("run_reset_outputs", 64'(out_vec()), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (499) @(posedge clk);
        @(negedge clk);
        check("midinit_we", 64'(bus.we), 64'd1);
        check("midinit_addr", 64'(bus.write_addr), 64'd499);
        #1;
        rst_n = 1'b0;
        #1;
        check("midinit_async_zero", 64'(out_vec()), 64'd0);
        repeat (3) @(posedge clk);
        run_init(we_cnt, bad, done_cyc, rdy_seen);
        check("reinit_we_cycles", 64'(we_cnt), 64'd2048);
        check("reinit_addr_seq", 64'(bad), 64'd0);
        check("reinit_done_cycle", 64'(done_cyc), 64'd2049);
        @(posedge clk); #1;
        bus.rd_valid = 2'b01; bus.rd_addr0 = 11'd700;
        cycle();
        check("reinit_rd700", obs_rsp_data, 64'd0);
        check("reinit_rd700_valid", 64'(obs_rsp_valid), 64'd1);
        bus.rd_valid = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
